// File: rtl/motoro3_step_pwm_gen.sv
// Six-step commutation generator with shadowed config and PWM'd high side.
// Optional dead time at each step change: define MOTORO3_DEADTIME_EN.
module motoro3_step_pwm_gen #(
   parameter int unsigned DEAD_CYC = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m3g_enable,
   input  logic [24:0] m3r_stepCNT_speedSET,
   input  logic [7:0]  m3r_power_percent,
   input  logic [11:0] m3r_pwmLenWant,
   input  logic [11:0] m3r_pwmMinMask,
   input  logic [1:0]  m3r_stepSplitMax,
   output logic [2:0]  m3g_step,
   output logic        m3g_stepTick,
   output logic        m3g_subTick,
   output logic [2:0]  m3g_gateHi,
   output logic [2:0]  m3g_gateLo
);

`ifdef MOTORO3_DEADTIME_EN
   localparam bit DEAD_EN = 1'b1;
`else
   localparam bit DEAD_EN = 1'b0;
`endif
   localparam int unsigned DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

   // High-side on-time: ~len*pct/100, clamped, suppressed below the minimum switchable pulse.
   function automatic logic [11:0] calc_on(input logic [11:0] len, input logic [7:0] pct,
                                           input logic [11:0] mask);
      logic [13:0] raw;
      logic [11:0] on;
      raw = 14'((26'(len) * 26'(pct) * 26'd41) >> 12);
      on  = (raw > 14'(len)) ? len : raw[11:0];
      if (on != 12'd0 && on < mask) on = 12'd0;
      return on;
   endfunction

   // Sub-step length; divide by 3 is an exact reciprocal multiply for 25-bit operands.
   function automatic logic [24:0] calc_seg(input logic [24:0] speed, input logic [1:0] split);
      case (split)
         2'd0:    calc_seg = speed;
         2'd1:    calc_seg = speed >> 1;
         2'd2:    calc_seg = 25'((51'(speed) * 51'd44739243) >> 27);
         default: calc_seg = speed >> 2;
      endcase
   endfunction

   function automatic logic [2:0] hi_phase(input logic [2:0] s);
      case (s)
         3'd0, 3'd1: hi_phase = 3'b001;
         3'd2, 3'd3: hi_phase = 3'b010;
         3'd4, 3'd5: hi_phase = 3'b100;
         default:    hi_phase = 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] lo_phase(input logic [2:0] s);
      case (s)
         3'd0, 3'd5: lo_phase = 3'b010;
         3'd1, 3'd2: lo_phase = 3'b100;
         3'd3, 3'd4: lo_phase = 3'b001;
         default:    lo_phase = 3'b000;
      endcase
   endfunction

   logic          en_q;
   logic [24:0]   speed_sh_q, speed_sh_d, seg_q, seg_d, step_cnt_q, step_cnt_d;
   logic [24:0]   sub_cnt_q, sub_cnt_d, seg_in;
   logic [1:0]    split_sh_q, split_sh_d, sub_k_q, sub_k_d;
   logic [11:0]   len_sh_q, len_sh_d, on_q, on_d, pwm_cnt_q, pwm_cnt_d, on_in;
   logic [2:0]    step_q, step_d, gate_hi_q, gate_hi_d, gate_lo_q, gate_lo_d;
   logic [DW-1:0] dead_cnt_q, dead_cnt_d;
   logic          step_tick_q, sub_tick_q, step_wrap, sub_evt, pwm_load, blank;

   assign seg_in = calc_seg(m3r_stepCNT_speedSET, m3r_stepSplitMax);
   assign on_in  = calc_on(m3r_pwmLenWant, m3r_power_percent, m3r_pwmMinMask);

   always_comb begin
      speed_sh_d = speed_sh_q;
      split_sh_d = split_sh_q;
      seg_d      = seg_q;
      step_cnt_d = step_cnt_q;
      sub_cnt_d  = sub_cnt_q;
      sub_k_d    = sub_k_q;
      step_d     = step_q;
      step_wrap  = 1'b0;
      sub_evt    = 1'b0;
      if (speed_sh_q != 25'd0) begin
         if (step_cnt_q == speed_sh_q - 25'd1) begin
            step_wrap  = 1'b1;
            step_cnt_d = 25'd0;
            step_d     = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
            speed_sh_d = m3r_stepCNT_speedSET;
            split_sh_d = m3r_stepSplitMax;
            seg_d      = seg_in;
            sub_cnt_d  = 25'd0;
            sub_k_d    = 2'd0;
         end else begin
            step_cnt_d = step_cnt_q + 25'd1;
            if (seg_q != 25'd0 && sub_k_q < split_sh_q && sub_cnt_q == seg_q - 25'd1) begin
               sub_evt   = 1'b1;
               sub_cnt_d = 25'd0;
               sub_k_d   = sub_k_q + 2'd1;
            end else begin
               sub_cnt_d = sub_cnt_q + 25'd1;
            end
         end
      end else begin
         // Locked motor never wraps, so keep accepting a new speed to restart it.
         speed_sh_d = m3r_stepCNT_speedSET;
         split_sh_d = m3r_stepSplitMax;
         seg_d      = seg_in;
      end

      pwm_load  = (len_sh_q == 12'd0) || (pwm_cnt_q == len_sh_q - 12'd1);
      pwm_cnt_d = pwm_load ? 12'd0 : pwm_cnt_q + 12'd1;
      len_sh_d  = pwm_load ? m3r_pwmLenWant : len_sh_q;
      on_d      = pwm_load ? on_in : on_q;

      dead_cnt_d = dead_cnt_q;
      if (DEAD_EN && step_wrap) dead_cnt_d = DW'(DEAD_CYC - 1);
      else if (dead_cnt_q != '0) dead_cnt_d = dead_cnt_q - 1'b1;
      blank = DEAD_EN && (step_wrap || dead_cnt_q != '0 ||
                          (speed_sh_q != 25'd0 && speed_sh_q <= 25'(DEAD_CYC)));

      gate_hi_d = (!blank && pwm_cnt_d < on_d) ? hi_phase(step_d) : 3'b000;
      gate_lo_d = blank ? 3'b000 : lo_phase(step_d);
   end

   always_ff @(posedge clk) begin
      if (rst || !m3g_enable || !en_q) begin
         en_q        <= !rst && m3g_enable;
         speed_sh_q  <= m3r_stepCNT_speedSET;
         split_sh_q  <= m3r_stepSplitMax;
         seg_q       <= seg_in;
         len_sh_q    <= m3r_pwmLenWant;
         on_q        <= on_in;
         step_cnt_q  <= 25'd0;
         sub_cnt_q   <= 25'd0;
         sub_k_q     <= 2'd0;
         pwm_cnt_q   <= 12'd0;
         step_q      <= 3'd0;
         dead_cnt_q  <= '0;
         step_tick_q <= 1'b0;
         sub_tick_q  <= 1'b0;
         gate_hi_q   <= 3'b000;
         gate_lo_q   <= 3'b000;
      end else begin
         speed_sh_q  <= speed_sh_d;
         split_sh_q  <= split_sh_d;
         seg_q       <= seg_d;
         len_sh_q    <= len_sh_d;
         on_q        <= on_d;
         step_cnt_q  <= step_cnt_d;
         sub_cnt_q   <= sub_cnt_d;
         sub_k_q     <= sub_k_d;
         pwm_cnt_q   <= pwm_cnt_d;
         step_q      <= step_d;
         dead_cnt_q  <= dead_cnt_d;
         step_tick_q <= step_wrap;
         sub_tick_q  <= step_wrap | sub_evt;
         gate_hi_q   <= gate_hi_d;
         gate_lo_q   <= gate_lo_d;
      end
   end

   assign m3g_step     = step_q;
   assign m3g_stepTick = step_tick_q;
   assign m3g_subTick  = sub_tick_q;
   assign m3g_gateHi   = gate_hi_q;
   assign m3g_gateLo   = gate_lo_q;

endmodule
